// File: rtl/qspi_read_pkg.sv
// Shared definitions for the QSPI read path: default word width, deserializer
// states, FIFO entry layout and the read opcode also used by the read engine.
package qspi_read_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [7:0] READ_OPCODE = 8'h03;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } deser_state_e;

    typedef struct packed {
        logic                      last;
        logic [DEFAULT_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/qspi_read_deser_if.sv
// Packed-word output stream of the QSPI read deserializer (valid/ready + last).
interface qspi_read_deser_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/qspi_read_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise the word is dropped.
module qspi_read_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    // Pointers are exactly log2(DEPTH) bits wide so they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/qspi_read_deser.sv
// Packs the read engine's qualified bit stream into DATA_W-bit words and queues
// them on a valid/ready stream. QSPI_READ_DESER_LSB_FIRST_EN selects LSB-first packing.
module qspi_read_deser
    import qspi_read_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          burst_start,
    input  logic [15:0]                   burst_bits,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          burst_done,
    qspi_read_deser_if.master             stream,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          trunc_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [0:0] S_IDLE   = ST_IDLE;
    localparam logic [0:0] S_ACTIVE = ST_ACTIVE;

    logic [0:0]        state_q, state_d;
    logic [15:0]       remain_q, remain_d, acc_remain;
    logic [CNT_W-1:0]  cnt_q, cnt_d, acc_cnt;
    logic [DATA_W-1:0] shift_q, shift_d, acc_shift, ins_shift, aligned;
    logic              push, push_last, trunc_set;
    logic [DATA_W:0]   head;
    logic              fifo_full, fifo_empty, pop;

`ifdef QSPI_READ_DESER_LSB_FIRST_EN
    assign ins_shift = shift_q | (DATA_W'(bit_in) << cnt_q);
    assign aligned   = acc_shift;
`else
    assign ins_shift = {shift_q[DATA_W-2:0], bit_in};
    // Left-align a short word so the received bits sit at the MSB end.
    assign aligned   = acc_shift << (CNT_W'(DATA_W) - acc_cnt);
`endif

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        acc_remain = remain_q;
        acc_cnt    = cnt_q;
        acc_shift  = shift_q;
        push       = 1'b0;
        push_last  = 1'b0;
        trunc_set  = 1'b0;
        if (state_q == S_ACTIVE) begin
            if (burst_start) begin
                // A new request aborts the running burst; its partial word is lost.
                trunc_set = 1'b1;
                remain_d  = burst_bits;
                cnt_d     = '0;
                shift_d   = '0;
                state_d   = (burst_bits != 16'd0) ? S_ACTIVE : S_IDLE;
            end else begin
                if (bit_valid) begin
                    acc_shift  = ins_shift;
                    acc_cnt    = cnt_q + 1'b1;
                    acc_remain = remain_q - 16'd1;
                    if (acc_cnt == CNT_W'(DATA_W) || acc_remain == 16'd0) begin
                        push      = 1'b1;
                        push_last = (acc_remain == 16'd0);
                    end
                end
                remain_d = acc_remain;
                cnt_d    = push ? '0 : acc_cnt;
                shift_d  = push ? '0 : acc_shift;
                if (acc_remain == 16'd0) begin
                    state_d = S_IDLE;
                end else if (burst_done) begin
                    // Evaluated after the same-cycle bit, on the updated counters.
                    trunc_set = 1'b1;
                    state_d   = S_IDLE;
                    remain_d  = '0;
                    cnt_d     = '0;
                    shift_d   = '0;
                    if (!push && acc_cnt != '0) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end
                end
            end
        end else if (burst_start && burst_bits != 16'd0) begin
            state_d  = S_ACTIVE;
            remain_d = burst_bits;
            cnt_d    = '0;
            shift_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            overflow  <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (trunc_set) trunc_err <= 1'b1;
        end
    end

    assign pop = !fifo_empty && stream.out_ready;

    qspi_read_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_last, aligned}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Head storage is not reset, so gate it to keep outputs at 0 when empty.
    assign stream.out_valid = !fifo_empty;
    assign stream.out_data  = fifo_empty ? '0 : head[DATA_W-1:0];
    assign stream.out_last  = !fifo_empty && head[DATA_W];

endmodule

// File: tb/tb_qspi_read_deser.sv
// Self-checking bench for qspi_read_deser: directed plan cases plus random bursts
// checked against a bit-list reference model.
module tb_qspi_read_deser;

    localparam int W = 8;
    localparam int D = 4;

    typedef logic [W:0] word_t;
    typedef word_t      wq_t[$];
    typedef bit         bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        burst_start = 1'b0;
    logic [15:0] burst_bits = 16'd0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        burst_done = 1'b0;
    logic [$clog2(D):0] fifo_level;
    logic        overflow;
    logic        trunc_err;

    int  checks = 0;
    int  passes = 0;
    wq_t got_q;

    qspi_read_deser_if #(.DATA_W(W)) sif ();

    qspi_read_deser #(.DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .burst_start (burst_start),
        .burst_bits  (burst_bits),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .burst_done  (burst_done),
        .stream      (sif),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .trunc_err   (trunc_err)
    );

    always #5 clk = ~clk;

    // Reference: chop the first k delivered bits into W-bit words.
    function automatic wq_t model(bq_t b, int n, int k);
        wq_t r;
        int  nw = (k + W - 1) / W;
        for (int i = 0; i < nw; i++) begin
            logic [W-1:0] w = '0;
            int cnt = (k - i * W < W) ? (k - i * W) : W;
            logic last;
            for (int j = 0; j < cnt; j++) begin
`ifdef QSPI_READ_DESER_LSB_FIRST_EN
                w[j] = b[i * W + j];
`else
                w[W - 1 - j] = b[i * W + j];
`endif
            end
            last = (i == nw - 1) && (k == n || cnt < W);
            r.push_back({last, w});
        end
        return r;
    endfunction

    function automatic bq_t bits_of(logic [31:0] v, int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(v[n - 1 - i]);
        return b;
    endfunction

    function automatic bq_t rand_bits(int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(1'($urandom_range(1)));
        return b;
    endfunction

    function automatic logic rnd_ready(int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic tick();
        if (sif.out_valid && sif.out_ready) got_q.push_back({sif.out_last, sif.out_data});
        @(posedge clk);
        #1;
    endtask

    task automatic drive_burst(bq_t b, int n, int k, int gap_pct, int ready_pct, bit done_last);
        burst_start   = 1'b1;
        burst_bits    = 16'(n);
        sif.out_ready = rnd_ready(ready_pct);
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < k; i++) begin
            int g = ($urandom_range(99) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
            bit_valid = 1'b0;
            repeat (g) begin
                sif.out_ready = rnd_ready(ready_pct);
                tick();
            end
            bit_in        = b[i];
            bit_valid     = 1'b1;
            burst_done    = done_last && (i == k - 1);
            sif.out_ready = rnd_ready(ready_pct);
            tick();
        end
        bit_valid  = 1'b0;
        burst_done = 1'b0;
    endtask

    task automatic drain(string name);
        sif.out_ready = 1'b1;
        for (int i = 0; i < 40 && sif.out_valid; i++) tick();
        checks++;
        if (sif.out_valid !== 1'b0) $display("FAIL %s drain timeout: out_valid=%b expected 0", name, sif.out_valid);
        else passes++;
    endtask

    task automatic test_reset();
        #3;
        checks += 6;
        if (sif.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", sif.out_valid); else passes++;
        if (sif.out_data !== '0) $display("FAIL reset out_data: got %h expected 00", sif.out_data); else passes++;
        if (sif.out_last !== 1'b0) $display("FAIL reset out_last: got %b expected 0", sif.out_last); else passes++;
        if (fifo_level !== '0) $display("FAIL reset fifo_level: got %0d expected 0", fifo_level); else passes++;
        if (overflow !== 1'b0) $display("FAIL reset overflow: got %b expected 0", overflow); else passes++;
        if (trunc_err !== 1'b0) $display("FAIL reset trunc_err: got %b expected 0", trunc_err); else passes++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_burst16();
        bq_t b = bits_of(32'hA53C, 16);
        wq_t e = '{{1'b0, 8'hA5}, {1'b1, 8'h3C}};
        got_q.delete();
        sif.out_ready = 1'b1;
        burst_start = 1'b1;
        burst_bits  = 16'd16;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bit_in    = b[i];
            bit_valid = 1'b1;
            if (i == 7) begin
                checks++;
                if (sif.out_valid !== 1'b0) $display("FAIL burst16 valid before 8th edge: got %b expected 0", sif.out_valid);
                else passes++;
            end
            tick();
            if (i == 7) begin
                checks++;
                if (sif.out_valid !== 1'b1) $display("FAIL burst16 valid after 8th bit: got %b expected 1", sif.out_valid);
                else passes++;
            end
        end
        bit_valid = 1'b0;
        drain("burst16");
        checks++;
        if (got_q.size() != e.size()) $display("FAIL burst16 count: got %0d expected %0d", got_q.size(), e.size());
        else passes++;
        foreach (e[i]) begin
            word_t g = '1;
            if (i < got_q.size()) g = got_q[i];
            checks++;
            if (g !== e[i]) $display("FAIL burst16 word%0d: got %h expected %h", i, g, e[i]);
            else passes++;
        end
    endtask

    task automatic test_burst12();
`ifdef QSPI_READ_DESER_LSB_FIRST_EN
        wq_t e = '{{1'b0, 8'h6D}, {1'b1, 8'h0B}};
`else
        wq_t e = '{{1'b0, 8'hB6}, {1'b1, 8'hD0}};
`endif
        got_q.delete();
        drive_burst(bits_of(32'hB6D, 12), 12, 12, 30, 60, 1'b0);
        drain("burst12");
        checks++;
        if (got_q.size() != e.size()) $display("FAIL burst12 count: got %0d expected %0d", got_q.size(), e.size());
        else passes++;
        foreach (e[i]) begin
            word_t g = '1;
            if (i < got_q.size()) g = got_q[i];
            checks++;
            if (g !== e[i]) $display("FAIL burst12 word%0d: got %h expected %h", i, g, e[i]);
            else passes++;
        end
        checks++;
        if (trunc_err !== 1'b0) $display("FAIL burst12 trunc_err: got %b expected 0", trunc_err); else passes++;
    endtask

    task automatic test_lsb_first();
`ifdef QSPI_READ_DESER_LSB_FIRST_EN
        word_t e = {1'b1, 8'h03};
`else
        word_t e = {1'b1, 8'hC0};
`endif
        got_q.delete();
        drive_burst(bits_of(32'hC0, 8), 8, 8, 0, 100, 1'b0);
        drain("lsb_first");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== e)
            $display("FAIL lsb_first word: got %0d words, first %h, expected 1 word %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : word_t'('1), e);
        else passes++;
    endtask

    task automatic test_zero_len();
        got_q.delete();
        drive_burst(rand_bits(8), 0, 8, 0, 100, 1'b0);
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        tick();
        checks += 3;
        if (fifo_level !== '0) $display("FAIL zero_len fifo_level: got %0d expected 0", fifo_level); else passes++;
        if (got_q.size() != 0) $display("FAIL zero_len words: got %0d expected 0", got_q.size()); else passes++;
        if (trunc_err !== 1'b0) $display("FAIL zero_len trunc_err: got %b expected 0", trunc_err); else passes++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int  n = int'($urandom_range(40, 1));
            bq_t b = rand_bits(n);
            bit  dl = 1'($urandom_range(1));
            wq_t e = model(b, n, n);
            got_q.delete();
            drive_burst(b, n, n, 50, 75, dl);
            if (!dl) begin
                burst_done = 1'b1;
                tick();
                burst_done = 1'b0;
            end
            drain("random");
            checks++;
            if (got_q.size() != e.size()) $display("FAIL random%0d count: got %0d expected %0d", t, got_q.size(), e.size());
            else passes++;
            foreach (e[i]) begin
                word_t g = '1;
                if (i < got_q.size()) g = got_q[i];
                checks++;
                if (g !== e[i]) $display("FAIL random%0d word%0d: got %h expected %h", t, i, g, e[i]);
                else passes++;
            end
        end
        checks += 2;
        if (trunc_err !== 1'b0) $display("FAIL random trunc_err: got %b expected 0", trunc_err); else passes++;
        if (overflow !== 1'b0) $display("FAIL random overflow: got %b expected 0", overflow); else passes++;
    endtask

    task automatic test_overflow();
        bq_t b = rand_bits(40);
        wq_t e = model(b, 40, 40);
        got_q.delete();
        drive_burst(b, 40, 40, 0, 0, 1'b0);
        tick();
        checks += 2;
        if (fifo_level !== 3'd4) $display("FAIL overflow fifo_level: got %0d expected 4", fifo_level); else passes++;
        if (overflow !== 1'b1) $display("FAIL overflow flag: got %b expected 1", overflow); else passes++;
        drain("overflow");
        checks++;
        if (got_q.size() != 4) $display("FAIL overflow count: got %0d expected 4", got_q.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            word_t g = '1;
            if (i < got_q.size()) g = got_q[i];
            checks++;
            if (g !== e[i]) $display("FAIL overflow word%0d: got %h expected %h", i, g, e[i]);
            else passes++;
        end
        checks++;
        if (overflow !== 1'b1) $display("FAIL overflow sticky: got %b expected 1", overflow); else passes++;
    endtask

    task automatic test_reset_mid();
        bq_t b = rand_bits(24);
        bq_t c = bits_of(32'hC3, 8);
        b[0] = 1'b1;
        got_q.delete();
        drive_burst(b, 24, 18, 0, 0, 1'b0);
        checks++;
        if (fifo_level !== 3'd2) $display("FAIL reset_mid queued: got %0d expected 2", fifo_level); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks += 6;
        if (sif.out_valid !== 1'b0) $display("FAIL reset_mid out_valid: got %b expected 0", sif.out_valid); else passes++;
        if (sif.out_data !== '0) $display("FAIL reset_mid out_data: got %h expected 00", sif.out_data); else passes++;
        if (sif.out_last !== 1'b0) $display("FAIL reset_mid out_last: got %b expected 0", sif.out_last); else passes++;
        if (fifo_level !== '0) $display("FAIL reset_mid fifo_level: got %0d expected 0", fifo_level); else passes++;
        if (overflow !== 1'b0) $display("FAIL reset_mid overflow: got %b expected 0", overflow); else passes++;
        if (trunc_err !== 1'b0) $display("FAIL reset_mid trunc_err: got %b expected 0", trunc_err); else passes++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        got_q.delete();
        drive_burst(c, 8, 8, 0, 100, 1'b0);
        drain("reset_mid");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, 8'hC3})
            $display("FAIL reset_mid post word: got %0d words, first %h, expected 1 word 1c3",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : word_t'('1));
        else passes++;
    endtask

    task automatic test_abort();
        bq_t b2 = rand_bits(8);
        wq_t e = model(b2, 8, 8);
        got_q.delete();
        drive_burst(rand_bits(16), 16, 5, 0, 100, 1'b0);
        checks++;
        if (trunc_err !== 1'b0) $display("FAIL abort trunc_err before: got %b expected 0", trunc_err); else passes++;
        drive_burst(b2, 8, 8, 20, 100, 1'b0);
        drain("abort");
        checks += 2;
        if (got_q.size() != 1 || got_q[0] !== e[0])
            $display("FAIL abort word: got %0d words, first %h, expected 1 word %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : word_t'('1), e[0]);
        else passes++;
        if (trunc_err !== 1'b1) $display("FAIL abort trunc_err: got %b expected 1", trunc_err); else passes++;
    endtask

    task automatic test_trunc();
        bq_t b = rand_bits(16);
        wq_t e = model(b, 16, 10);
        got_q.delete();
        drive_burst(b, 16, 10, 0, 100, 1'b1);
        tick();
        drain("trunc");
        checks += 2;
        if (got_q.size() != 2) $display("FAIL trunc count: got %0d expected 2", got_q.size()); else passes++;
        if (trunc_err !== 1'b1) $display("FAIL trunc trunc_err: got %b expected 1", trunc_err); else passes++;
        foreach (e[i]) begin
            word_t g = '1;
            if (i < got_q.size()) g = got_q[i];
            checks++;
            if (g !== e[i]) $display("FAIL trunc word%0d: got %h expected %h", i, g, e[i]);
            else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            bit_in    = 1'($urandom_range(1));
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        tick();
        checks += 2;
        if (fifo_level !== '0) $display("FAIL trunc idle fifo_level: got %0d expected 0", fifo_level); else passes++;
        if (got_q.size() != 2) $display("FAIL trunc idle words: got %0d expected 2", got_q.size()); else passes++;
    endtask

    initial begin
        sif.out_ready = 1'b0;
        test_reset();
        test_burst16();
        test_burst12();
        test_lsb_first();
        test_zero_len();
        test_random();
        test_overflow();
        test_reset_mid();
        test_abort();
        test_trunc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
